// File: rtl/model_transformer_pkg.sv
// Shared definitions for the transformer matrix-vector product engine:
// default widths and size limits, FSM state type and MODE_IN encodings.
package model_transformer_pkg;

   localparam int DATA_SIZE    = 64;
   localparam int CONTROL_SIZE = 4;
   localparam int SIZE_I_MAX   = 64;
   localparam int SIZE_J_MAX   = 64;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_ACCUMULATE = 2'd1,
      ST_OUTPUT     = 2'd2
   } state_t;

   localparam logic [1:0] MODE_PLAIN     = 2'd0;
   localparam logic [1:0] MODE_BIAS      = 2'd1;
   localparam logic [1:0] MODE_RELU      = 2'd2;
   localparam logic [1:0] MODE_BIAS_RELU = 2'd3;

endpackage

// File: rtl/model_transformer_mac.sv
// Registered signed multiply-accumulate with synchronous clear.
// Optional macro: MODEL_TRANSFORMER_SATURATION_EN (clamp product and sum
// instead of wrapping).
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clr        clear accumulator (wins over en)
//   en         accumulate a*b this cycle
//   a, b       signed operands
//   sum        accumulator plus current product (value loaded when en)
module model_transformer_mac #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum
);

   logic [W-1:0] acc_q, acc_d;
   logic [W-1:0] prod;

`ifdef MODEL_TRANSFORMER_SATURATION_EN
   localparam logic [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
   logic [2*W-1:0] prod_full;
   logic [W:0]     sum_w;

   always_comb begin
      // low 2W bits of the product of sign-extended operands are exact
      prod_full = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
      if (prod_full[2*W-1:W-1] != {(W+1){prod_full[2*W-1]}})
         prod = prod_full[2*W-1] ? S_MIN : S_MAX;
      else
         prod = prod_full[W-1:0];
      sum_w = {acc_q[W-1], acc_q} + {prod[W-1], prod};
      if (sum_w[W] != sum_w[W-1])
         sum = sum_w[W] ? S_MIN : S_MAX;
      else
         sum = sum_w[W-1:0];
   end
`else
   always_comb begin
      prod = a * b;
      sum  = acc_q + prod;
   end
`endif

   always_comb begin
      acc_d = acc_q;
      if (clr)
         acc_d = '0;
      else if (en)
         acc_d = sum;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc_q <= '0;
      else
         acc_q <= acc_d;
   end

endmodule

// File: rtl/model_transformer_matrix_vector_product.sv
// Streaming signed matrix-vector product y = A*x with optional per-row bias
// and ReLU. One A/x element pair per handshake, one result per row.
// Optional macro: MODEL_TRANSFORMER_SATURATION_EN (saturating arithmetic).
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   START, READY, DONE  job control (READY high in IDLE, DONE pulses on last row)
//   MODE_IN             [0] add bias, [1] ReLU
//   SIZE_I_IN/J_IN      row/column counts, captured on START, clipped to maxima
//   DATA_IN_*           element stream: A row-major, x re-sent per row, bias per row
//   DATA_OUT_*          registered row result and its row index
//
// state         | meaning
// IDLE          | waiting for START, READY high
// ACCUMULATE    | consuming element pairs of the current row
// OUTPUT        | one cycle presenting the row result, then next row or IDLE
module model_transformer_matrix_vector_product #(
   parameter int DATA_SIZE    = model_transformer_pkg::DATA_SIZE,
   parameter int CONTROL_SIZE = model_transformer_pkg::CONTROL_SIZE,
   parameter int SIZE_I_MAX   = model_transformer_pkg::SIZE_I_MAX,
   parameter int SIZE_J_MAX   = model_transformer_pkg::SIZE_J_MAX
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    START,
   output logic                    READY,
   output logic                    DONE,
   input  logic [CONTROL_SIZE-1:0] MODE_IN,
   input  logic [DATA_SIZE-1:0]    SIZE_I_IN,
   input  logic [DATA_SIZE-1:0]    SIZE_J_IN,
   input  logic                    DATA_IN_VALID,
   output logic                    DATA_IN_READY,
   input  logic [DATA_SIZE-1:0]    DATA_A_IN,
   input  logic [DATA_SIZE-1:0]    DATA_B_IN,
   input  logic [DATA_SIZE-1:0]    DATA_BIAS_IN,
   output logic                    DATA_OUT_VALID,
   output logic [DATA_SIZE-1:0]    DATA_OUT,
   output logic [DATA_SIZE-1:0]    DATA_OUT_I
);
   import model_transformer_pkg::*;

   localparam logic [DATA_SIZE-1:0] I_MAX = DATA_SIZE'(SIZE_I_MAX);
   localparam logic [DATA_SIZE-1:0] J_MAX = DATA_SIZE'(SIZE_J_MAX);
   localparam logic [DATA_SIZE-1:0] ONE   = DATA_SIZE'(1);

   state_t               state_q, state_d;
   logic [1:0]           mode_q, mode_d;
   logic [DATA_SIZE-1:0] size_i_q, size_i_d, size_j_q, size_j_d;
   logic [DATA_SIZE-1:0] i_q, i_d, j_q, j_d;
   logic [DATA_SIZE-1:0] data_out_q, data_out_d, data_out_i_q, data_out_i_d;
   logic                 data_out_valid_q, data_out_valid_d, done_q, done_d;

   logic [DATA_SIZE-1:0] size_i_clip, size_j_clip, acc_nxt, row_result;
   logic                 zero_job, hs, last_col, last_row, mac_clr;
   logic                 mode_unused;

   function automatic logic [DATA_SIZE-1:0] add_bias(input logic [DATA_SIZE-1:0] x,
                                                      input logic [DATA_SIZE-1:0] y);
`ifdef MODEL_TRANSFORMER_SATURATION_EN
      logic [DATA_SIZE:0] s;
      s = {x[DATA_SIZE-1], x} + {y[DATA_SIZE-1], y};
      if (s[DATA_SIZE] != s[DATA_SIZE-1])
         return s[DATA_SIZE] ? {1'b1, {(DATA_SIZE-1){1'b0}}} : {1'b0, {(DATA_SIZE-1){1'b1}}};
      return s[DATA_SIZE-1:0];
`else
      return x + y;
`endif
   endfunction

   assign mode_unused = ^MODE_IN[CONTROL_SIZE-1:2];
   assign size_i_clip = (SIZE_I_IN > I_MAX) ? I_MAX : SIZE_I_IN;
   assign size_j_clip = (SIZE_J_IN > J_MAX) ? J_MAX : SIZE_J_IN;
   assign zero_job    = (size_i_clip == '0) || (size_j_clip == '0);
   assign hs          = (state_q == ST_ACCUMULATE) && DATA_IN_VALID;
   assign last_col    = hs && (j_q == size_j_q - ONE);
   assign last_row    = (i_q == size_i_q - ONE);

   model_transformer_mac #(.W(DATA_SIZE)) u_mac (
      .clk (CLK),
      .rst (RST),
      .clr (mac_clr),
      .en  (hs),
      .a   (DATA_A_IN),
      .b   (DATA_B_IN),
      .sum (acc_nxt)
   );

   // Row result is formed on the last handshake from the MAC's next value so
   // that DATA_OUT can be a flop and still appear in the OUTPUT cycle.
   always_comb begin
      row_result = acc_nxt;
      case (mode_q)
         MODE_BIAS, MODE_BIAS_RELU: row_result = add_bias(acc_nxt, DATA_BIAS_IN);
         MODE_PLAIN, MODE_RELU:     row_result = acc_nxt;
         default:                   row_result = acc_nxt;
      endcase
      if ((mode_q == MODE_RELU || mode_q == MODE_BIAS_RELU) && row_result[DATA_SIZE-1])
         row_result = '0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:       if (START && !zero_job) state_d = ST_ACCUMULATE;
         ST_ACCUMULATE: if (last_col) state_d = ST_OUTPUT;
         ST_OUTPUT:     state_d = last_row ? ST_IDLE : ST_ACCUMULATE;
         default:       state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      READY          = (state_q == ST_IDLE);
      DATA_IN_READY  = (state_q == ST_ACCUMULATE);
      DATA_OUT_VALID = data_out_valid_q;
      DONE           = done_q;
      DATA_OUT       = data_out_q;
      DATA_OUT_I     = data_out_i_q;
   end

   always_comb begin
      mode_d           = mode_q;
      size_i_d         = size_i_q;
      size_j_d         = size_j_q;
      i_d              = i_q;
      j_d              = j_q;
      data_out_d       = data_out_q;
      data_out_i_d     = data_out_i_q;
      data_out_valid_d = 1'b0;
      done_d           = 1'b0;
      mac_clr          = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               mode_d   = MODE_IN[1:0];
               size_i_d = size_i_clip;
               size_j_d = size_j_clip;
               i_d      = '0;
               j_d      = '0;
               mac_clr  = 1'b1;
               // empty job: finishes immediately without leaving IDLE
               done_d   = zero_job;
            end
         end
         ST_ACCUMULATE: begin
            if (hs) begin
               j_d = j_q + ONE;
               if (last_col) begin
                  data_out_d       = row_result;
                  data_out_i_d     = i_q;
                  data_out_valid_d = 1'b1;
                  done_d           = last_row;
               end
            end
         end
         ST_OUTPUT: begin
            j_d     = '0;
            i_d     = i_q + ONE;
            mac_clr = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mode_q           <= '0;
         size_i_q         <= '0;
         size_j_q         <= '0;
         i_q              <= '0;
         j_q              <= '0;
         data_out_q       <= '0;
         data_out_i_q     <= '0;
         data_out_valid_q <= 1'b0;
         done_q           <= 1'b0;
      end else begin
         mode_q           <= mode_d;
         size_i_q         <= size_i_d;
         size_j_q         <= size_j_d;
         i_q              <= i_d;
         j_q              <= j_d;
         data_out_q       <= data_out_d;
         data_out_i_q     <= data_out_i_d;
         data_out_valid_q <= data_out_valid_d;
         done_q           <= done_d;
      end
   end

endmodule
